// File: rtl/serial_eeprom_pkg.sv
// Shared definitions for the emulated 93Cx6 serial EEPROM: opcodes, control bits,
// FSM states and the size-to-address-width mapping.
package serial_eeprom_pkg;

    typedef enum logic [1:0] {
        OpExt   = 2'b00,
        OpWrite = 2'b01,
        OpRead  = 2'b10,
        OpErase = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        ExtEwds = 2'b00,
        ExtWral = 2'b01,
        ExtEral = 2'b10,
        ExtEwen = 2'b11
    } ext_e;

    typedef enum logic [1:0] {
        StIdle,
        StLocal,
        StRun,
        StWaitMcu
    } state_e;

    localparam int unsigned CtrlEraseBit = 6;
    localparam int unsigned CtrlWriteBit = 5;
    localparam int unsigned CtrlReadBit  = 4;
    localparam int unsigned RamAddrW     = 10;
    localparam int unsigned RamWords     = 1 << RamAddrW;

    function automatic logic [3:0] addr_width(input logic [1:0] size);
        case (size)
            2'd0:    return 4'd6;
            2'd1:    return 4'd8;
            default: return 4'd10;
        endcase
    endfunction

endpackage

// File: rtl/serial_eeprom_spi_mux.sv
// SPI output stage: registers the selected data source and gates the inverted system
// clock so slaves sample on the SClk falling edge.
module spi_mux #(
    parameter int unsigned SIZE = 1
) (
    input  logic            Clk,
    input  logic            ClockRunning,
    input  logic            ClockStretch,
    input  logic [SIZE-1:0] InSPIDo,
    input  logic [SIZE-1:0] InSPISel,
    output logic            OutSPIDo,
    output logic            OutSPIClk
);

    always_ff @(posedge Clk) begin
        OutSPIDo <= |(InSPIDo & InSPISel);
    end

    assign OutSPIClk = ~Clk & ClockRunning & ~ClockStretch;

endmodule

// File: rtl/serial_eeprom.sv
// Emulated 93Cx6 serial EEPROM: host registers, 1024x16 shadow RAM, and forwarding of
// write-class commands to the MCU as a single SPI frame.
module serial_eeprom
    import serial_eeprom_pkg::*;
(
    input  logic        SClk,
    input  logic        nReset,
    input  logic        nWE,
    input  logic        nOE,
    input  logic [7:0]  WriteData,
    input  logic        SelSerialCtrl,
    input  logic        SelSerialComLo,
    input  logic        SelSerialComHi,
    input  logic        SelSerialDataLo,
    input  logic        SelSerialDataHi,
    input  logic [1:0]  EEPROMSize,
    input  logic        MCUReadyFallingEdge,
    output logic [7:0]  SerialCtrl,
    output logic [15:0] SerialCom,
    output logic [15:0] SerialData,
    output logic        SPISel,
    output logic        SPIDo,
    output logic        SPIClk
);

    logic        nwe_q;
    logic [15:0] com_q, data_q;
    logic        we_en_q, ready_q, rdone_q, is_read_q;
    state_e      state_q;
    logic [31:0] shift_q;
    logic [5:0]  bits_left_q;
    logic        clk_run_q, spi_sel_q, send_busy_q, mcu_seen_q;
    logic        fill_busy_q;
    logic [RamAddrW-1:0] fill_addr_q, fill_end_q;
    logic [15:0] fill_val_q;
    logic [15:0] rd_q;
    logic        unused_noe;

    logic [3:0]  aw;
    logic [15:0] com_shift;
    logic [RamAddrW-1:0] addr_mask, cmd_addr, ext_shift, ram_addr;
    logic        cmd_start, wr_edge, ctrl_go, forward, frame_long, erase_kind;
    opcode_e     cmd_op;
    ext_e        cmd_ext;

    assign unused_noe = nOE;

    always_comb begin
        aw         = addr_width(EEPROMSize);
        com_shift  = com_q >> aw;
        addr_mask  = RamAddrW'((11'd1 << aw) - 11'd1);
        cmd_addr   = com_q[RamAddrW-1:0] & addr_mask;
        ext_shift  = cmd_addr >> (aw - 4'd2);
        cmd_start  = com_shift[2];
        cmd_op     = opcode_e'(com_shift[1:0]);
        cmd_ext    = ext_e'(ext_shift[1:0]);
        wr_edge    = ~nwe_q & nWE;
        ctrl_go    = wr_edge & SelSerialCtrl & (state_q == StIdle);
        erase_kind = (cmd_op == OpErase) || (cmd_op == OpExt && cmd_ext == ExtEral);
        forward    = cmd_start && we_en_q &&
                     (cmd_op == OpWrite || cmd_op == OpErase ||
                      (cmd_op == OpExt && (cmd_ext == ExtWral || cmd_ext == ExtEral)));
        // Erase outranks write, so only a lone write request carries the data word.
        frame_long = WriteData[CtrlWriteBit] & ~WriteData[CtrlEraseBit];
    end

    // Shadow RAM: the fill engine owns the port while busy, otherwise it reads the
    // command address every cycle so READ data is ready one cycle after capture.
    logic [15:0] ram [RamWords];
    assign ram_addr = fill_busy_q ? fill_addr_q : cmd_addr;

    always_ff @(posedge SClk) begin
        if (fill_busy_q) begin
            ram[ram_addr] <= fill_val_q;
        end
        rd_q <= ram[ram_addr];
    end

    always_ff @(posedge SClk) begin
        if (!nReset) begin
            nwe_q       <= 1'b1;
            com_q       <= '0;
            data_q      <= '0;
            we_en_q     <= 1'b0;
            ready_q     <= 1'b1;
            rdone_q     <= 1'b0;
            is_read_q   <= 1'b0;
            state_q     <= StIdle;
            shift_q     <= '0;
            bits_left_q <= '0;
            clk_run_q   <= 1'b0;
            spi_sel_q   <= 1'b0;
            send_busy_q <= 1'b0;
            mcu_seen_q  <= 1'b0;
            fill_busy_q <= 1'b0;
            fill_addr_q <= '0;
            fill_end_q  <= '0;
            fill_val_q  <= '0;
        end else begin
            nwe_q <= nWE;
            if (wr_edge) begin
                if (SelSerialComLo)  com_q[7:0]   <= WriteData;
                if (SelSerialComHi)  com_q[15:8]  <= WriteData;
                if (SelSerialDataLo) data_q[7:0]  <= WriteData;
                if (SelSerialDataHi) data_q[15:8] <= WriteData;
            end

            // Frame sequencer: bits, then one clock-stopped cycle, then SPISel drops.
            if (send_busy_q) begin
                if (bits_left_q != 6'd0) begin
                    shift_q     <= shift_q << 1;
                    bits_left_q <= bits_left_q - 6'd1;
                    clk_run_q   <= 1'b1;
                end else if (clk_run_q) begin
                    clk_run_q <= 1'b0;
                end else begin
                    spi_sel_q   <= 1'b0;
                    send_busy_q <= 1'b0;
                end
            end

            if (fill_busy_q) begin
                if (fill_addr_q == fill_end_q) begin
                    fill_busy_q <= 1'b0;
                end else begin
                    fill_addr_q <= fill_addr_q + 1'b1;
                end
            end

            if (!send_busy_q && MCUReadyFallingEdge) begin
                mcu_seen_q <= 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (ctrl_go) begin
                        rdone_q <= 1'b0;
                        if (cmd_start) begin
                            ready_q   <= 1'b0;
                            is_read_q <= (cmd_op == OpRead);
                            if (forward) begin
                                shift_q     <= {com_q, data_q};
                                bits_left_q <= frame_long ? 6'd32 : 6'd16;
                                spi_sel_q   <= 1'b1;
                                send_busy_q <= 1'b1;
                                mcu_seen_q  <= 1'b0;
                                fill_busy_q <= 1'b1;
                                fill_addr_q <= (cmd_op == OpExt) ? '0 : cmd_addr;
                                fill_end_q  <= (cmd_op == OpExt) ? addr_mask : cmd_addr;
                                fill_val_q  <= erase_kind ? 16'hFFFF : data_q;
                                state_q     <= StRun;
                            end else begin
                                if (cmd_op == OpExt && cmd_ext == ExtEwen) we_en_q <= 1'b1;
                                if (cmd_op == OpExt && cmd_ext == ExtEwds) we_en_q <= 1'b0;
                                state_q <= StLocal;
                            end
                        end
                    end
                end
                StLocal: begin
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                    if (is_read_q) begin
                        data_q  <= rd_q;
                        rdone_q <= 1'b1;
                    end
                end
                StRun: begin
                    if (!send_busy_q && !fill_busy_q) state_q <= StWaitMcu;
                end
                StWaitMcu: begin
                    if (mcu_seen_q || MCUReadyFallingEdge) begin
                        ready_q <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    spi_mux #(
        .SIZE(1)
    ) u_spi_mux (
        .Clk          (SClk),
        .ClockRunning (clk_run_q),
        .ClockStretch (1'b0),
        .InSPIDo      (shift_q[31] & (bits_left_q != 6'd0)),
        .InSPISel     (spi_sel_q & nReset),
        .OutSPIDo     (SPIDo),
        .OutSPIClk    (SPIClk)
    );

    assign SerialCtrl = {6'b0, ready_q, rdone_q};
    assign SerialCom  = com_q;
    assign SerialData = data_q;
    assign SPISel     = spi_sel_q;

endmodule

// File: tb/tb_serial_eeprom.sv
// Directed bench for serial_eeprom with a behavioural command model and SPI frame monitor.
module tb_serial_eeprom;

    logic        SClk = 1'b0;
    logic        nReset = 1'b0;
    logic        nWE = 1'b1;
    logic        nOE = 1'b1;
    logic [7:0]  WriteData = 8'h00;
    logic        SelSerialCtrl = 1'b0, SelSerialComLo = 1'b0, SelSerialComHi = 1'b0;
    logic        SelSerialDataLo = 1'b0, SelSerialDataHi = 1'b0;
    logic [1:0]  EEPROMSize = 2'd0;
    logic        MCUReadyFallingEdge = 1'b0;
    logic [7:0]  SerialCtrl;
    logic [15:0] SerialCom, SerialData;
    logic        SPISel, SPIDo, SPIClk;

    serial_eeprom dut (
        .SClk                (SClk),
        .nReset              (nReset),
        .nWE                 (nWE),
        .nOE                 (nOE),
        .WriteData           (WriteData),
        .SelSerialCtrl       (SelSerialCtrl),
        .SelSerialComLo      (SelSerialComLo),
        .SelSerialComHi      (SelSerialComHi),
        .SelSerialDataLo     (SelSerialDataLo),
        .SelSerialDataHi     (SelSerialDataHi),
        .EEPROMSize          (EEPROMSize),
        .MCUReadyFallingEdge (MCUReadyFallingEdge),
        .SerialCtrl          (SerialCtrl),
        .SerialCom           (SerialCom),
        .SerialData          (SerialData),
        .SPISel              (SPISel),
        .SPIDo               (SPIDo),
        .SPIClk              (SPIClk)
    );

    always #5 SClk = ~SClk;

    int vectors = 0;
    int miscompares = 0;

    // Model of the programmer-visible state.
    logic [15:0] m_ram [1024];
    logic [15:0] m_com = 16'h0, m_data = 16'h0;
    bit          m_we = 1'b0, m_rdone = 1'b0;
    bit          chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge SClk) begin
        if (chk_en) begin
            check("idle_ctrl", {24'd0, SerialCtrl}, {30'd0, 1'b1, m_rdone});
            check("idle_com", {16'd0, SerialCom}, {16'd0, m_com});
            check("idle_data", {16'd0, SerialData}, {16'd0, m_data});
            check("idle_spisel", {31'd0, SPISel}, 32'd0);
        end
    end

    // Slave-side frame capture on SPIClk rising edges.
    logic [31:0] mon_bits = 32'd0;
    int          mon_cnt = 0;
    logic [31:0] fr_bits [$];
    int          fr_len [$];

    always @(posedge SPIClk) begin
        if (SPISel) begin
            mon_bits = {mon_bits[30:0], SPIDo};
            mon_cnt++;
        end
    end

    always @(negedge SPISel) begin
        fr_bits.push_back(mon_bits);
        fr_len.push_back(mon_cnt);
        mon_bits = 32'd0;
        mon_cnt  = 0;
    end

    task automatic reg_write(input int sel, input logic [7:0] val);
        @(posedge SClk); #1;
        WriteData       = val;
        SelSerialCtrl   = (sel == 0);
        SelSerialComLo  = (sel == 1);
        SelSerialComHi  = (sel == 2);
        SelSerialDataLo = (sel == 3);
        SelSerialDataHi = (sel == 4);
        nWE = 1'b0;
        @(posedge SClk); #1;
        nWE = 1'b1;
        @(posedge SClk); #1;
        {SelSerialCtrl, SelSerialComLo, SelSerialComHi, SelSerialDataLo, SelSerialDataHi} = '0;
    endtask

    task automatic set_com(input logic [15:0] v);
        reg_write(2, v[15:8]);
        m_com[15:8] = v[15:8];
        reg_write(1, v[7:0]);
        m_com[7:0] = v[7:0];
    endtask

    task automatic set_data(input logic [15:0] v);
        reg_write(4, v[15:8]);
        m_data[15:8] = v[15:8];
        reg_write(3, v[7:0]);
        m_data[7:0] = v[7:0];
    endtask

    // Applies one Ctrl write to the model; returns the frame the MCU must receive.
    task automatic model_exec(input logic [7:0] ctrl, output int len, output logic [31:0] frame,
                              output bit active);
        int unsigned aw;
        int unsigned addr;
        int unsigned op;
        int unsigned ext;
        bit          start;
        logic [15:0] v;
        aw    = (EEPROMSize == 2'd0) ? 6 : (EEPROMSize == 2'd1) ? 8 : 10;
        addr  = m_com % (1 << aw);
        op    = (m_com >> aw) % 4;
        start = ((m_com >> (aw + 2)) % 2) == 1;
        ext   = addr >> (aw - 2);
        len    = 0;
        frame  = 32'd0;
        active = start;
        m_rdone = 1'b0;
        if (!start) return;
        if (op == 2) begin
            m_data  = m_ram[addr];
            m_rdone = 1'b1;
        end else if (op == 0 && ext == 3) begin
            m_we = 1'b1;
        end else if (op == 0 && ext == 0) begin
            m_we = 1'b0;
        end else if (m_we) begin
            v = (op == 3 || (op == 0 && ext == 2)) ? 16'hFFFF : m_data;
            if (op == 0) begin
                for (int i = 0; i < (1 << aw); i++) m_ram[i] = v;
            end else begin
                m_ram[addr] = v;
            end
            len   = ctrl[6] ? 16 : (ctrl[5] ? 32 : 16);
            frame = (len == 32) ? {m_com, m_data} : {16'd0, m_com};
        end
    endtask

    task automatic do_op(input string name, input logic [7:0] ctrl, input logic [15:0] cmd,
                         input bit early_mcu, input int lit_len, input logic [31:0] lit_frame);
        int          exp_len;
        logic [31:0] exp_frame;
        bit          active;
        int          n;
        set_com(cmd);
        model_exec(ctrl, exp_len, exp_frame, active);
        chk_en = 1'b0;
        fr_bits.delete();
        fr_len.delete();
        reg_write(0, ctrl);
        check({name, "_ready_after_ctrl"}, {31'd0, SerialCtrl[1]}, {31'd0, !active});
        if (exp_len != 0) begin
            n = 0;
            while (fr_len.size() == 0 && n < 200) begin
                MCUReadyFallingEdge = early_mcu && (n == 3);
                @(posedge SClk); #1;
                n++;
            end
            MCUReadyFallingEdge = 1'b0;
            check({name, "_frame_timeout"}, {31'd0, n < 200}, 32'd1);
            repeat (3) @(posedge SClk);
            #1;
            check({name, "_busy_until_mcu"}, {31'd0, SerialCtrl[1]}, 32'd0);
            MCUReadyFallingEdge = 1'b1;
            @(posedge SClk); #1;
            MCUReadyFallingEdge = 1'b0;
        end
        n = 0;
        while (!SerialCtrl[1] && n < 2000) begin
            @(posedge SClk); #1;
            n++;
        end
        check({name, "_ready_timeout"}, {31'd0, SerialCtrl[1]}, 32'd1);
        if (exp_len != 0 && fr_len.size() != 0) begin
            check({name, "_frame_len"}, fr_len[0], exp_len);
            check({name, "_frame_bits"}, fr_bits[0], exp_frame);
            check({name, "_frame_lit"}, fr_bits[0], lit_frame);
            check({name, "_frame_len_lit"}, fr_len[0], lit_len);
        end else begin
            check({name, "_frame_count"}, fr_len.size(), (exp_len != 0) ? 1 : 0);
        end
        chk_en = 1'b1;
        repeat (2) @(posedge SClk);
        #1;
    endtask

    task automatic do_read(input string name, input logic [15:0] cmd, input logic [15:0] lit);
        do_op(name, 8'h10, cmd, 1'b0, 0, 32'd0);
        check({name, "_data"}, {16'd0, SerialData}, {16'd0, lit});
        check({name, "_done"}, {31'd0, SerialCtrl[0]}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge SClk);
        #1;
        check("rst_ctrl", {24'd0, SerialCtrl}, 32'h02);
        check("rst_com", {16'd0, SerialCom}, 32'h0);
        check("rst_data", {16'd0, SerialData}, 32'h0);
        check("rst_spi", {30'd0, SPISel, SPIDo}, 32'h0);
        @(negedge SClk);
        check("rst_spiclk", {31'd0, SPIClk}, 32'h0);
        @(posedge SClk); #1;
        nReset = 1'b1;
        chk_en = 1'b1;

        do_op("ewen", 8'h10, 16'h0130, 1'b0, 0, 32'd0);
        do_op("eral", 8'h40, 16'h0120, 1'b0, 16, 32'h0000_0120);
        do_read("rd3_erased", 16'h0183, 16'hFFFF);

        set_data(16'hABBA);
        do_op("wr3", 8'h20, 16'h0143, 1'b1, 32, 32'h0143_ABBA);
        do_read("rd3", 16'h0183, 16'hABBA);

        set_data(16'h1234);
        do_op("wr63", 8'h20, 16'h017F, 1'b0, 32, 32'h017F_1234);
        set_data(16'h7001);
        do_op("wr0", 8'h20, 16'h0140, 1'b0, 32, 32'h0140_7001);
        do_read("rd63", 16'h01BF, 16'h1234);
        do_read("rd0", 16'h0180, 16'h7001);

        EEPROMSize = 2'd2;
        set_data(16'h5A5A);
        do_op("wr3ff", 8'h20, 16'h17FF, 1'b0, 32, 32'h17FF_5A5A);
        do_read("rd3ff", 16'h1BFF, 16'h5A5A);
        EEPROMSize = 2'd0;

        set_data(16'h3333);
        do_op("wral", 8'h20, 16'h0110, 1'b0, 32, 32'h0110_3333);
        do_read("rd0_wral", 16'h0180, 16'h3333);
        do_read("rd63_wral", 16'h01BF, 16'h3333);
        EEPROMSize = 2'd3;
        do_read("rd3ff_kept", 16'h1BFF, 16'h5A5A);
        EEPROMSize = 2'd0;

        do_op("ewds", 8'h10, 16'h0100, 1'b0, 0, 32'd0);
        do_op("erase_dis", 8'h40, 16'h01C0, 1'b0, 0, 32'd0);
        do_read("rd0_kept", 16'h0180, 16'h3333);
        do_op("ewen2", 8'h10, 16'h0130, 1'b0, 0, 32'd0);
        do_op("erase0", 8'h40, 16'h01C0, 1'b0, 16, 32'h0000_01C0);
        do_read("rd0_erased", 16'h0180, 16'hFFFF);

        do_op("nostart", 8'h10, 16'h0083, 1'b0, 0, 32'd0);

        set_data(16'h0BEE);
        do_op("prio", 8'h70, 16'h0145, 1'b0, 16, 32'h0000_0145);
        do_read("rd5", 16'h0185, 16'h0BEE);

        // Reset in the middle of a forwarded WRITE.
        set_data(16'h5555);
        set_com(16'h0146);
        chk_en = 1'b0;
        reg_write(0, 8'h20);
        m_ram[6] = 16'h5555;
        repeat (5) @(posedge SClk);
        #1;
        check("midframe_sel", {31'd0, SPISel}, 32'd1);
        nReset = 1'b0;
        @(posedge SClk); #1;
        check("midrst_sel", {31'd0, SPISel}, 32'd0);
        check("midrst_ctrl", {24'd0, SerialCtrl}, 32'h02);
        nReset = 1'b1;
        m_com = 16'h0; m_data = 16'h0; m_we = 1'b0; m_rdone = 1'b0;
        @(posedge SClk); #1;
        fr_bits.delete();
        fr_len.delete();
        chk_en = 1'b1;
        set_data(16'h1111);
        do_op("wr_after_rst", 8'h20, 16'h0146, 1'b0, 0, 32'd0);
        do_read("rd6", 16'h0186, 16'h5555);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
